cvp14_core: RTL and testbench

- 16-bit vector processor core with unified instruction/data memory; the bench attaches it to an external word-addressed memory model.
- Architectural state:
  - 16-bit PC.
  - Scalar registers S0–S7, 16 bits each.
  - Vector registers V0–V7, each 16 lanes × 16 bits.
- Executes one instruction at a time using a multi-cycle fetch/execute FSM.
- Arithmetic is 16-bit two's-complement integer; overflow is reported on V.

---
 rtl/cvp14_core.sv | 221 ++++++++++++++++++++++
 tb/tb_cvp14_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cvp14_core.sv
// cvp14_core: 16-bit vector core with 8 scalar and 8 vector registers and a multi-cycle fetch/execute FSM.
// Define SATURATE_EN to clamp overflowing VADD/SMUL/VDOT results instead of wrapping them.
module cvp14_core #(
  parameter int          VLEN     = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  output logic        V
);

  localparam int IW = $clog2(VLEN);
  localparam logic [IW:0] CNT_END  = (IW+1)'(VLEN);
  localparam logic [IW:0] CNT_LAST = (IW+1)'(VLEN - 1);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] MEM    = 2'd3;

  localparam logic [3:0] OP_VADD = 4'h0;
  localparam logic [3:0] OP_VDOT = 4'h1;
  localparam logic [3:0] OP_SMUL = 4'h2;
  localparam logic [3:0] OP_SST  = 4'h3;
  localparam logic [3:0] OP_VLD  = 4'h4;
  localparam logic [3:0] OP_VST  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SLH  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;

  logic [1:0]  state;
  logic [15:0] pc, ir, addrq, doutq, acc;
  logic [IW:0] cnt;
  logic        vflag, dotovf;
  logic [15:0] sreg [0:7];
  logic [15:0] vreg [0:7][0:VLEN-1];

  logic [3:0]    op;
  logic [2:0]    fd, fa, fb;
  logic [15:0]   off6, off12, base;
  logic [IW-1:0] lane;

  assign op    = ir[15:12];
  assign fd    = ir[11:9];
  assign fa    = ir[8:6];
  assign fb    = ir[5:3];
  assign off6  = {{10{ir[5]}}, ir[5:0]};
  assign off12 = {{4{ir[11]}}, ir[11:0]};
  assign base  = sreg[fa] + off6;
  assign lane  = cnt[IW-1:0];

  // Result in [15:0], overflow flag in [16].
  function automatic logic [16:0] addOvf(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] s;
    logic        o;
    s = x + y;
    o = (x[15] == y[15]) && (s[15] != x[15]);
`ifdef SATURATE_EN
    if (o) s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, s};
  endfunction

  function automatic logic [16:0] mulOvf(input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] p;
    logic [15:0]        r;
    logic               o;
    p = $signed(x) * $signed(y);
    r = p[15:0];
    o = (p[31:15] != {17{p[15]}});
`ifdef SATURATE_EN
    if (o) r = p[31] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, r};
  endfunction

  logic [15:0] vaddres [0:VLEN-1];
  logic [15:0] smulres [0:VLEN-1];
  logic        vaddovf, smulovf;
  logic [16:0] dotprod, dotsum;

  always_comb begin : laneMath
    logic [16:0] addT, mulT;
    addT    = '0;
    mulT    = '0;
    vaddovf = 1'b0;
    smulovf = 1'b0;
    for (int i = 0; i < VLEN; i++) begin
      addT       = addOvf(vreg[fa][i], vreg[fb][i]);
      mulT       = mulOvf(vreg[fa][i], sreg[fb]);
      vaddres[i] = addT[15:0];
      smulres[i] = mulT[15:0];
      vaddovf    = vaddovf | addT[16];
      smulovf    = smulovf | mulT[16];
    end
  end

  assign dotprod = mulOvf(vreg[fa][lane], vreg[fb][lane]);
  assign dotsum  = addOvf(acc, dotprod[15:0]);

  // Bus outputs are decoded from state; idle cycles replay the last address/data.
  logic [15:0] addrc, doutc;
  logic        rdc, wrc;

  always_comb begin
    addrc = addrq;
    doutc = doutq;
    rdc   = 1'b0;
    wrc   = 1'b0;
    case (state)
      FETCH: begin
        addrc = pc;
        rdc   = 1'b1;
      end
      EXEC: if (op == OP_SST) begin
        addrc = base;
        wrc   = 1'b1;
        doutc = sreg[fd];
      end
      MEM: if (op == OP_VLD && cnt != CNT_END) begin
        addrc = base + 16'(cnt);
        rdc   = 1'b1;
      end else if (op == OP_VST) begin
        addrc = base + 16'(cnt);
        wrc   = 1'b1;
        doutc = vreg[fd][lane];
      end
      default: ;
    endcase
  end

  assign Addr    = addrc;
  assign DataOut = doutc;
  assign RD      = rdc & ~Reset;
  assign WR      = wrc & ~Reset;
  assign V       = vflag;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      addrq  <= '0;
      doutq  <= '0;
      acc    <= '0;
      cnt    <= '0;
      vflag  <= 1'b0;
      dotovf <= 1'b0;
      for (int r = 0; r < 8; r++) begin
        sreg[r] <= '0;
        for (int i = 0; i < VLEN; i++) vreg[r][i] <= '0;
      end
    end else begin
      addrq <= addrc;
      doutq <= doutc;
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir     <= DataIn;
          pc     <= pc + 16'd1;
          cnt    <= '0;
          acc    <= '0;
          dotovf <= 1'b0;
          if (DataIn[15:12] == OP_VDOT || DataIn[15:12] == OP_VLD || DataIn[15:12] == OP_VST)
            state <= MEM;
          else
            state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (op)
            OP_VADD: begin
              for (int i = 0; i < VLEN; i++) vreg[fd][i] <= vaddres[i];
              vflag <= vaddovf;
            end
            OP_SMUL: begin
              for (int i = 0; i < VLEN; i++) vreg[fd][i] <= smulres[i];
              vflag <= smulovf;
            end
            OP_SLL:  sreg[fd][7:0]  <= ir[7:0];
            OP_SLH:  sreg[fd][15:8] <= ir[7:0];
            OP_J:    pc <= pc + off12;
            default: ;
          endcase
        end
        MEM: begin
          case (op)
            // Read data lags its address by one cycle, so lane i lands while lane i+1 is issued.
            OP_VLD: begin
              if (cnt != '0) vreg[fd][lane - 1'b1] <= DataIn;
              if (cnt == CNT_END) state <= FETCH;
              else                cnt   <= cnt + 1'b1;
            end
            OP_VST: begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) state <= FETCH;
            end
            OP_VDOT: begin
              acc    <= dotsum[15:0];
              dotovf <= dotovf | dotprod[16] | dotsum[16];
              cnt    <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                sreg[fd] <= dotsum[15:0];
                vflag    <= dotovf | dotprod[16] | dotsum[16];
                state    <= FETCH;
              end
            end
            default: state <= FETCH;
          endcase
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cvp14_core.sv
// tb_cvp14_core: runs directed programs on cvp14_core against a 256-word memory model.
// Register contents are observed only through the stores they produce.
`timescale 1ns/1ps
module tb_cvp14_core;

  logic        Clk1;
  logic        Reset;
  logic [15:0] DataIn, Addr, DataOut;
  logic        RD, WR, V;

  cvp14_core dut (
    .Clk1(Clk1), .Reset(Reset), .DataIn(DataIn), .Addr(Addr),
    .RD(RD), .WR(WR), .DataOut(DataOut), .V(V)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  // Memory model: one-cycle read latency; the bench loader writes only while the core is idle in reset.
  logic [15:0] mem [0:255];
  logic [15:0] rdata;
  logic        tbWe;
  logic [7:0]  tbAddr;
  logic [15:0] tbData;

  always @(posedge Clk1) begin
    if (WR)        mem[Addr[7:0]] <= DataOut;
    else if (tbWe) mem[tbAddr]    <= tbData;
    if (RD) rdata <= mem[Addr[7:0]];
  end
  assign DataIn = rdata;

  // Bus monitor, cleared whenever reset is held.
  int          wrCount, collide, dotSeen;
  logic [15:0] lastRd, maxRd;
  logic        vAtDot, vAtAdd;

  always @(negedge Clk1) begin
    if (Reset) begin
      wrCount = 0; collide = 0; dotSeen = 0;
      lastRd = '0; maxRd = '0;
      vAtDot = 1'b1; vAtAdd = 1'b1;
    end else begin
      if (WR) wrCount++;
      if (WR && RD) collide++;
      if (RD) begin
        lastRd = Addr;
        if (Addr > maxRd) maxRd = Addr;
      end
      if (WR && Addr == 16'h0050) begin vAtDot = V; dotSeen++; end
      if (WR && Addr == 16'h0030) vAtAdd = V;
    end
  end

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [15:0] d);
    tbAddr = a; tbData = d; tbWe = 1'b1;
    @(posedge Clk1); #1;
    tbWe = 1'b0;
  endtask

  task automatic fillMemory(input logic [15:0] val);
    for (int i = 0; i < 256; i++) applyStimulus(8'(i), val);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge Clk1);
    #1 Reset = 1'b0;
  endtask

  logic [15:0] progC [0:18] = '{
    16'h6034, 16'h7012, 16'h6E20, 16'h41C0, 16'h0800, 16'h59D0, 16'h6203,
    16'h2408, 16'h1400, 16'h6C40, 16'h5580, 16'h3590, 16'h31C0, 16'h31FF,
    16'h6A60, 16'h4340, 16'h0248, 16'h5350, 16'h8FFF
  };

`ifdef SATURATE_EN
  localparam logic [15:0] OVF_LANE = 16'h7FFF;
`else
  localparam logic [15:0] OVF_LANE = 16'hFFFE;
`endif

  int seen;

  initial begin
    Reset = 1'b1; tbWe = 1'b0; tbAddr = '0; tbData = '0;

    // Program A: VST V3,S0,0x10 aborted by reset after five lanes.
    fillMemory(16'hDEAD);
    applyStimulus(8'h00, 16'h5610);
    applyStimulus(8'h01, 16'h8FFF);
    releaseReset();
    @(negedge Clk1);
    checkOutput("reset_addr", Addr, 16'h0000);
    checkOutput("reset_rd", {15'b0, RD}, 16'd1);
    checkOutput("reset_wr", {15'b0, WR}, 16'd0);
    checkOutput("reset_v",  {15'b0, V},  16'd0);
    seen = 0;
    for (int c = 0; c < 100 && seen < 5; c++) begin
      @(negedge Clk1);
      if (WR) seen++;
    end
    checkOutput("abort_wr_seen", 16'(seen), 16'd5);
    @(posedge Clk1); #1 Reset = 1'b1; #1;
    checkOutput("abort_wr_gated", {15'b0, WR}, 16'd0);
    @(posedge Clk1); @(negedge Clk1);
    checkOutput("abort_lane0", mem[8'h10], 16'h0000);
    checkOutput("abort_lane4", mem[8'h14], 16'h0000);
    checkOutput("abort_lane5", mem[8'h15], 16'hDEAD);
    checkOutput("abort_lane15", mem[8'h1F], 16'hDEAD);

    // Program B: SLL/SLH/SLL then the J -1 halt idiom.
    applyStimulus(8'h00, 16'h6034);
    applyStimulus(8'h01, 16'h7012);
    applyStimulus(8'h02, 16'h6E20);
    applyStimulus(8'h03, 16'h8FFF);
    releaseReset();
    repeat (40) @(negedge Clk1);
    checkOutput("halt_wr_count", 16'(wrCount), 16'd0);
    checkOutput("halt_pc", lastRd, 16'h0003);
    checkOutput("halt_max_fetch", maxRd, 16'h0003);
    checkOutput("halt_v", {15'b0, V}, 16'd0);
    @(posedge Clk1); #1 Reset = 1'b1;

    // Program C: vector load/add/store, SMUL, VDOT, SST and an overflowing VADD.
    fillMemory(16'hDEAD);
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h20 + i), 16'(i + 1));
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h60 + i), 16'h7FFF);
    for (int i = 0; i < 19; i++) applyStimulus(8'(i), progC[i]);
    releaseReset();
    repeat (400) @(negedge Clk1);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("vadd_lane%0d", i), mem[8'(8'h30 + i)], 16'(2 * (i + 1)));
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("smul_lane%0d", i), mem[8'(8'h40 + i)], 16'(3 * (i + 1)));
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("ovf_lane%0d", i), mem[8'(8'h70 + i)], OVF_LANE);
    checkOutput("vdot_sum", mem[8'h50], 16'h05D8);
    checkOutput("sst_s0", mem[8'h20], 16'h1234);
    checkOutput("sst_neg_off", mem[8'h1F], 16'h1234);
    checkOutput("vadd_v_clear", {15'b0, vAtAdd}, 16'd0);
    checkOutput("vdot_v_clear", {15'b0, vAtDot}, 16'd0);
    checkOutput("vdot_store_seen", 16'(dotSeen), 16'd1);
    checkOutput("ovf_v_set", {15'b0, V}, 16'd1);
    checkOutput("wr_count", 16'(wrCount), 16'd51);
    checkOutput("rd_wr_overlap", 16'(collide), 16'd0);
    checkOutput("final_pc", lastRd, 16'h0012);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
